// File: rtl/aes_cipher_iter_pkg.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter_pkg
//   Shared AES helpers for the iterative cipher core: FSM state type,
//   round-count function, GF(2^8) arithmetic and the S-box.
//   The S-box is computed (multiplicative inverse via x^254, then the affine
//   transform) rather than stored as a table.
// -----------------------------------------------------------------------------
package aes_cipher_iter_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 through an addition chain; 0 maps to 0 naturally.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gmul(b, b);
    x3   = gmul(x2, b);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// -----------------------------------------------------------------------------
// aes_round
//   One combinational AES encryption round:
//   SubBytes, ShiftRows, MixColumns (skipped when final_i), AddRoundKey.
//   st_i    : state in, byte 0 in [127:120], column-major
//   rk_i    : round key
//   final_i : last round of the block
//   st_o    : state out
// -----------------------------------------------------------------------------
module aes_round
  import aes_cipher_iter_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] st_o
);

  always_comb begin
    logic [7:0]   sh [0:15];
    logic [127:0] shf;
    logic [127:0] mx;
    logic [7:0]   a0, a1, a2, a3;
    shf = '0;
    mx  = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    // Byte (row r, column c) sits at index 4c+r; row r rotates left by r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sh[4*c+r] = sbox(st_i[8*(15 - (4*((c + r) % 4) + r)) +: 8]);
      end
    end
    for (int i = 0; i < 16; i++) shf[8*(15-i) +: 8] = sh[i];
    for (int c = 0; c < 4; c++) begin
      a0 = sh[4*c];
      a1 = sh[4*c+1];
      a2 = sh[4*c+2];
      a3 = sh[4*c+3];
      mx[32*(3-c) +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    st_o = (final_i ? shf : mx) ^ rk_i;
  end

endmodule

// File: rtl/key_expansion.sv
// -----------------------------------------------------------------------------
// key_expansion
//   Combinational AES key schedule for NK = 4/6/8.
//   key_i : cipher key, word 0 in the MSBs
//   rk_o  : round keys 0..NR, rk_o[r] = schedule words 4r..4r+3 (4r in MSBs)
// -----------------------------------------------------------------------------
module key_expansion
  import aes_cipher_iter_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [NK*32-1:0] key_i,
  output logic [127:0]     rk_o [0:nr_of(NK)]
);

  localparam int NR = nr_of(NK);
  localparam int NW = 4 * (NR + 1);

  always_comb begin
    logic [31:0] w [0:NW-1];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    t  = '0;
    for (int i = 0; i < NK; i++) w[i] = key_i[32*(NK-1-i) +: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        // AES-256 adds an extra SubWord half-way through each key period
        t = subword(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter
//   Iterative AES-128/192/256 encryption, one round per clock, valid/ready
//   on both sides. The key is captured with each block, so the key source may
//   change freely while a block is in flight.
//   Ports:
//     clk, rst            clock (rising), async active-high reset
//     in_valid/in_ready   input handshake for data_in and key
//     data_in [127:0]     plaintext, byte 0 = [127:120]
//     key [NK*32-1:0]     cipher key, word 0 in the MSBs
//     out_valid/out_ready output handshake for data_out
//     data_out [127:0]    ciphertext
//     busy                block in flight
//   Build option AES_OUT_BUF_EN: result goes to a one-entry output buffer and
//   the core returns to IDLE immediately, overlapping the next block with the
//   wait for out_ready. Without it the core waits in DONE until the result
//   is taken.
// -----------------------------------------------------------------------------
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    data_in,
  input  logic [NK*32-1:0] key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    data_out,
  output logic            busy
);

  localparam int NR = nr_of(NK);
  localparam int RW = $clog2(NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("aes_cipher_iter: NK must be 4, 6 or 8");
  end

  fsm_t            state_q, state_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic            ovalid_q, ovalid_d;
  logic [127:0]    dout_q, dout_d;
  logic [127:0]    st_q, st_d;
  logic [NK*32-1:0] key_q, key_d;
  logic [127:0]    rk [0:NR];
  logic [127:0]    rnd_out;
  logic            last_rnd;

  assign last_rnd = (rnd_q == RW'(NR));

  key_expansion #(.NK(NK)) u_kexp (
    .key_i (key_q),
    .rk_o  (rk)
  );

  aes_round u_round (
    .st_i    (st_q),
    .rk_i    (rk[rnd_q]),
    .final_i (last_rnd),
    .st_o    (rnd_out)
  );

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    ovalid_d = ovalid_q;
    dout_d   = dout_q;
    st_d     = st_q;
    key_d    = key_q;
    if (ovalid_q && out_ready) ovalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Round key 0 is the key itself, so whitening uses the live input.
          key_d   = key;
          st_d    = data_in ^ key[NK*32-1 -: 128];
          rnd_d   = RW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (!last_rnd) begin
          st_d  = rnd_out;
          rnd_d = rnd_q + RW'(1);
        end else begin
`ifdef AES_OUT_BUF_EN
          // Hold at the final round until the buffer is free (or frees now).
          if (!ovalid_q || out_ready) begin
            st_d     = rnd_out;
            dout_d   = rnd_out;
            ovalid_d = 1'b1;
            rnd_d    = '0;
            state_d  = IDLE;
          end
`else
          st_d     = rnd_out;
          dout_d   = rnd_out;
          ovalid_d = 1'b1;
          rnd_d    = '0;
          state_d  = DONE;
`endif
        end
      end
      DONE: begin
        if (ovalid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      ovalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      ovalid_q <= ovalid_d;
      dout_q   <= dout_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance.
  always_ff @(posedge clk) begin
    st_q  <= st_d;
    key_q <= key_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ovalid_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
module tb_aes_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         irdy [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bsy  [3];
  logic [127:0] din  [3];
  logic [127:0] dout [3];
  logic [255:0] kin  [3];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb [0:255];

  always #5 clk = ~clk;

  aes_cipher_iter #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .data_in(din[0]),
    .key(kin[0][255:128]), .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]),
    .busy(bsy[0]));
  aes_cipher_iter #(.NK(6)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .data_in(din[1]),
    .key(kin[1][255:64]), .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]),
    .busy(bsy[1]));
  aes_cipher_iter #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .data_in(din[2]),
    .key(kin[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout[2]),
    .busy(bsy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box by brute-force inverse search and the bitwise affine definition.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw_ref(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0]  w [0:59];
    logic [7:0]   a [0:3][0:3];
    logic [7:0]   b [0:3][0:3];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw_ref({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw_ref(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          b[r][c] = sb[a[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < nr) begin
          a[0][c] = gm(b[0][c], 8'h02) ^ gm(b[1][c], 8'h03) ^ b[2][c] ^ b[3][c];
          a[1][c] = b[0][c] ^ gm(b[1][c], 8'h02) ^ gm(b[2][c], 8'h03) ^ b[3][c];
          a[2][c] = b[0][c] ^ b[1][c] ^ gm(b[2][c], 8'h02) ^ gm(b[3][c], 8'h03);
          a[3][c] = gm(b[0][c], 8'h03) ^ b[1][c] ^ b[2][c] ^ gm(b[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) a[r][c] = b[r][c];
        end
        for (int r = 0; r < 4; r++) a[r][c] = a[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = a[r][c];
    return res;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] r256();
    return {r128(), r128()};
  endfunction

  // ---------------- known vectors ----------------
  logic [255:0] K1, K2, K3, K4;
  logic [127:0] P1, P2, C1, C2, C3, C4;

  // One block with out_ready low until the result appears; latency counted
  // in edges including the acceptance edge.
  task automatic run_block(input int idx, input int nk, input logic [255:0] k,
                           input logic [127:0] pt, input logic [127:0] exp, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    chk({tag, "_in_ready"}, 128'(irdy[idx]), 128'd1);
    kin[idx] = k;
    din[idx] = pt;
    iv[idx] = 1'b1;
    ordy[idx] = 1'b0;
    @(posedge clk);
    #1;
    iv[idx] = 1'b0;
    kin[idx] = r256();
    din[idx] = r128();
    chk({tag, "_busy"}, 128'(bsy[idx]), 128'd1);
    chk({tag, "_in_ready_low"}, 128'(irdy[idx]), 128'd0);
    lat = 1;
    seen = ov[idx];
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      kin[idx] = r256();
      din[idx] = r128();
      lat++;
      seen = ov[idx];
    end
    chk({tag, "_latency"}, 128'(lat), 128'(nk + 7));
    chk({tag, "_data"}, dout[idx], exp);
    @(negedge clk);
    ordy[idx] = 1'b1;
    @(posedge clk);
    #1;
    ordy[idx] = 1'b0;
    chk({tag, "_ov_drop"}, 128'(ov[idx]), 128'd0);
  endtask

  task automatic stall_test();
    logic [127:0] d0;
    bit stable;
    bit rdy_ok;
    int n;
    @(negedge clk);
    kin[0] = K2;
    din[0] = P2;
    iv[0] = 1'b1;
    ordy[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_ov", 128'(ov[0]), 128'd1);
    d0 = dout[0];
    stable = 1'b1;
    rdy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifndef AES_OUT_BUF_EN
      iv[0] = 1'b1;
      din[0] = r128();
      kin[0] = r256();
      if (irdy[0] !== 1'b0) rdy_ok = 1'b0;
`endif
      if (ov[0] !== 1'b1 || dout[0] !== d0) stable = 1'b0;
    end
    iv[0] = 1'b0;
    chk("stall_stable", 128'(stable), 128'd1);
    chk("stall_in_ready", 128'(rdy_ok), 128'd1);
    chk("stall_data", d0, C2);
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("stall_ov_drop", 128'(ov[0]), 128'd0);
    chk("stall_ready_after", 128'(irdy[0]), 128'd1);
    chk("stall_busy_after", 128'(bsy[0]), 128'd0);
  endtask

  task automatic reset_test();
    bit seen;
    @(negedge clk);
    kin[0] = K1;
    din[0] = P1;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("rstmid_in_ready", 128'(irdy[0]), 128'd1);
    chk("rstmid_busy", 128'(bsy[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready_after", 128'(irdy[0]), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) seen = 1'b1;
    end
    chk("rstmid_no_ov", 128'(seen), 128'd0);
    ordy[0] = 1'b0;
  endtask

  task automatic rand_run(input int idx, input int nk, input int nblk);
    logic [127:0] q [$];
    logic [127:0] e;
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    while ((acc < nblk || q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      kin[idx] = r256();
      din[idx] = r128();
      iv[idx] = (acc < nblk) && ($urandom_range(0, 2) != 0);
      ordy[idx] = ($urandom_range(0, 3) != 0);
      if (iv[idx] && irdy[idx]) begin
        q.push_back(aes_ref(kin[idx], nk, din[idx]));
        acc++;
      end
      if (ov[idx] && ordy[idx]) begin
        if (q.size() == 0) begin
          chk("rand_extra_output", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("rand_nk%0d_data", nk), dout[idx], e);
        end
      end
    end
    @(negedge clk);
    iv[idx] = 1'b0;
    ordy[idx] = 1'b0;
    chk($sformatf("rand_nk%0d_accepted", nk), 128'(acc), 128'(nblk));
    chk($sformatf("rand_nk%0d_pending", nk), 128'(q.size()), 128'd0);
  endtask

  initial begin
    K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    K2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    K3 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    K4 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    P1 = 128'h00112233445566778899aabbccddeeff;
    P2 = 128'h3243f6a8885a308d313198a2e0370734;
    C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    C3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    C4 = 128'h8ea2b7ca516745bfeafc49904b496089;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
      din[i] = '0;
      kin[i] = '0;
    end
    build_sbox();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_in_ready%0d", i), 128'(irdy[i]), 128'd1);
      chk($sformatf("reset_out_valid%0d", i), 128'(ov[i]), 128'd0);
      chk($sformatf("reset_data_out%0d", i), dout[i], 128'd0);
      chk($sformatf("reset_busy%0d", i), 128'(bsy[i]), 128'd0);
    end
    rst = 1'b0;

    chk("model_v1", aes_ref(K1, 4, P1), C1);
    chk("model_v2", aes_ref(K2, 4, P2), C2);
    chk("model_v3", aes_ref(K3, 6, P1), C3);
    chk("model_v4", aes_ref(K4, 8, P1), C4);

    run_block(0, 4, K1, P1, C1, "v1_aes128");
    run_block(0, 4, K2, P2, C2, "v2_aes128");
    run_block(1, 6, K3, P1, C3, "v3_aes192");
    run_block(2, 8, K4, P1, C4, "v4_aes256");

    stall_test();
    reset_test();
    run_block(0, 4, K1, P1, C1, "post_reset_v1");

    rand_run(0, 4, 15);
    rand_run(1, 6, 10);
    rand_run(2, 8, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
